uart_event_encoder: RTL

UART_EVENT_ENCODER -- requirements
Module: uart_event_encoder

---
 rtl/uart_cmd_pkg.sv | 51 +++++
 rtl/uart_evt_arbiter.sv | 28 ++
 rtl/uart_event_encoder.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_pkg
// Brief    : Shared UART command constants, event bit indices and FSM
//            encoding for the event encoder and the command decoder.
// Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    localparam int EVT_NUM = 7;

    localparam int EVT_LEFT        = 0;
    localparam int EVT_TOP         = 1;
    localparam int EVT_BOTTOM      = 2;
    localparam int EVT_RIGHT       = 3;
    localparam int EVT_SCAN_START  = 4;
    localparam int EVT_SCAN_RST    = 5;
    localparam int EVT_USER_RST    = 6;

    localparam logic [7:0] c_char_left       = 8'h61; // 'a'
    localparam logic [7:0] c_char_top        = 8'h77; // 'w'
    localparam logic [7:0] c_char_bottom     = 8'h73; // 's'
    localparam logic [7:0] c_char_right      = 8'h64; // 'd'
    localparam logic [7:0] c_char_scan_start = 8'h62; // 'b'
    localparam logic [7:0] c_char_scan_rst   = 8'h6E; // 'n'
    localparam logic [7:0] c_char_user_rst   = 8'h6D; // 'm'
    localparam logic [7:0] c_char_cr         = 8'h0D;
    localparam logic [7:0] c_char_lf         = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND_CHAR = 2'd1,
        ST_SEND_CR   = 2'd2,
        ST_SEND_LF   = 2'd3
    } enc_state_t;

    function automatic logic [7:0] evt_char(input logic [2:0] idx);
        case (idx)
            3'd0:    evt_char = c_char_left;
            3'd1:    evt_char = c_char_top;
            3'd2:    evt_char = c_char_bottom;
            3'd3:    evt_char = c_char_right;
            3'd4:    evt_char = c_char_scan_start;
            3'd5:    evt_char = c_char_scan_rst;
            3'd6:    evt_char = c_char_user_rst;
            default: evt_char = 8'h00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_evt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_evt_arbiter
// Brief    : Combinational lowest-index priority selector over pending events.
// Revision : 1.0 - initial release
// ============================================================================
module uart_evt_arbiter
    import uart_cmd_pkg::*;
(
    input  logic [EVT_NUM-1:0] i_pending,
    output logic [2:0]         o_idx,
    output logic               o_valid
);

    // Scanning downwards lets the lowest set bit be the last (winning) write.
    always_comb begin
        o_idx   = 3'd0;
        o_valid = 1'b0;
        for (int i = EVT_NUM - 1; i >= 0; i--) begin
            if (i_pending[i]) begin
                o_idx   = 3'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : uart_event_encoder
// Brief    : Latches event pulses as pending flags and emits one ASCII command
//            byte per event (optionally CR LF terminated) to a UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_event_encoder
    import uart_cmd_pkg::*;
#(
    parameter bit TERMINATE = 1'b1
) (
    input  logic               I_sys_clk,
    input  logic               I_rst,
    input  logic [EVT_NUM-1:0] I_event,
    input  logic               I_tx_ready,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_data_valid,
    output logic [EVT_NUM-1:0] o_pending,
    output logic               o_busy,
    output logic               o_overflow
);

    enc_state_t         state_q,    state_d;
    logic [EVT_NUM-1:0] pending_q,  pending_d;
    logic [7:0]         tx_data_q,  tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               busy_q,     busy_d;
    logic               overflow_q, overflow_d;

    logic [2:0]         w_sel_idx;
    logic               w_sel_valid;
    logic [EVT_NUM-1:0] w_clear;
    logic               w_xfer;

    uart_evt_arbiter u_arbiter (
        .i_pending (pending_q),
        .o_idx     (w_sel_idx),
        .o_valid   (w_sel_valid)
    );

    assign w_xfer = tx_valid_q & I_tx_ready;

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        w_clear    = '0;

        case (state_q)
            ST_IDLE: begin
                if (w_sel_valid) begin
                    w_clear    = 7'(1) << w_sel_idx;
                    tx_data_d  = evt_char(w_sel_idx);
                    tx_valid_d = 1'b1;
                    state_d    = ST_SEND_CHAR;
                end
            end
            ST_SEND_CHAR: begin
                if (w_xfer) begin
                    if (TERMINATE) begin
                        tx_data_d = c_char_cr;
                        state_d   = ST_SEND_CR;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_SEND_CR: begin
                if (w_xfer) begin
                    tx_data_d = c_char_lf;
                    state_d   = ST_SEND_LF;
                end
            end
            ST_SEND_LF: begin
                if (w_xfer) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase

        // A new event on the bit being selected re-arms it, so set wins over clear.
        overflow_d = |(I_event & pending_q & ~w_clear);
        pending_d  = (pending_q & ~w_clear) | I_event;
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_tx_data       = tx_data_q;
    assign o_tx_data_valid = tx_valid_q;
    assign o_pending       = pending_q;
    assign o_busy          = busy_q;
    assign o_overflow      = overflow_q;

endmodule
`default_nettype wire
